serial_sub: RTL and testbench
=============================

# serial_sub

Bit-serial unsigned subtractor, the sequential counterpart of the team's ripple-carry adder. It computes a − b − bin one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. A start/busy/done handshake sits in front of it. It is used where area matters more than latency, and as the subtraction stage for later multi-cycle arithmetic blocks (restoring divider).

## Interface
Parameters:
- WIDTH, 4: operand and result width in bits (≥ 2).

Ports:
- clk  input  1: single clock; all state updates on the rising edge.
- rst_n  input  1: reset, synchronous and active-low.
- start  input  1: request a subtraction; sampled on a rising edge only when busy = 0.
- a  input  WIDTH: minuend, unsigned; captured on an accepted start.
- b  input  WIDTH: subtrahend, unsigned; captured on an accepted start.
- bin  input  1: borrow-in; captured on an accepted start.
- busy  output  1: high while a subtraction is in progress.
- done  output  1: one-cycle pulse; diff and bout are valid.
- diff  output  WIDTH: (a − b − bin) mod 2^WIDTH.
- bout  output  1: borrow-out, 1 iff a < b + bin (unsigned).

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- IDLE → RUN on start. Capture a, b, bin into internal shift registers and the borrow FF. Clear the bit counter.
- RUN: on each edge:
  - d = a[0] ^ b[0] ^ br.
  - br ← (~a[0] & b[0]) | (~(a[0] ^ b[0]) & br).
  - Shift the a and b registers right. Shift d into the MSB of the result register. Increment the counter.
- RUN → DONE on the edge that processes bit WIDTH−1, i.e. when counter = WIDTH−1.
- DONE: done = 1 and bout = final br. Next edge: go to RUN if start, else to IDLE.
- diff and bout hold their last result until the next completion. They do not change during RUN: the result register is internal and is copied to diff on the RUN→DONE edge.
- start is ignored while busy = 1. There is no queuing and no error flag.
- start is accepted in DONE exactly as in IDLE. This gives back-to-back operations.
- The bit counter is ceil(log2(WIDTH)) bits wide and does not wrap in normal use. It is cleared on every accepted start.

## Timing
- Reset (rst_n = 0 at an edge) values: state = IDLE, busy = 0, done = 0, diff = 0, bout = 0, counter = 0, borrow FF = 0.
- Reset asserted mid-RUN aborts the operation on that edge. No done pulse is produced, and diff/bout return to 0.
- If start and rst_n = 0 occur at the same edge, reset wins and start is dropped.
- If start is accepted at edge E0:
  - busy = 1 from after E0 until after E0+WIDTH.
  - done = 1 for exactly the one cycle after E0+WIDTH.
  - diff and bout are updated at E0+WIDTH.
- Latency is WIDTH+1 edges from the start edge to the done cycle. Back-to-back throughput is one result per WIDTH+1 cycles.
- busy and done are never high in the same cycle.
- Inputs a, b and bin may change freely after the start edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- serial_sub_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a localparam function for the counter width.
- Sub-module full_sub (1-bit, combinational): inputs x, y, bi; outputs d, bo. It is instantiated once in the RUN datapath.
- The top level contains the FSM, the three shift registers, the counter and the borrow FF.

## Test plan
All scenarios use WIDTH = 4.
- a=7, b=3, bin=0, start → done exactly 5 cycles after the start edge, diff=4, bout=0. busy is high for 4 cycles before done.
- a=3, b=4, bin=1 → diff=0xE, bout=1. a=0, b=0, bin=1 → diff=0xF, bout=1. a=0xF, b=0xF, bin=0 → diff=0, bout=0.
- start pulsed again 2 cycles into RUN with different operands → it is ignored. The first result completes unchanged, with one done pulse.
- start held high continuously with operands changing each op → done every 5 cycles. Each result matches the operands sampled at its own accepted start.
- rst_n=0 during RUN cycle 2 → the next cycle shows busy=0, done=0, diff=0, bout=0, and no done pulse follows. A subsequent start works normally.
- Exhaustive sweep of all a, b, bin (512 ops) against a reference model of (a−b−bin) mod 16 and a<b+bin → zero mismatches.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and helpers for the bit-serial subtractor.
//   state_e    : FSM state encoding (IDLE, RUN, DONE)
//   cnt_width  : width of the bit counter for a given operand width
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must address bit indices 0..width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    if (width <= 2) begin
      return 1;
    end else begin
      return $clog2(width);
    end
  endfunction

endpackage

// File: rtl/serial_sub_if.sv
// serial_sub_if: request/result bundle of the bit-serial subtractor.
//   master : drives start, a, b, bin; observes busy, done, diff, bout
//   slave  : the subtractor side (opposite directions)
interface serial_sub_if #(
  parameter int WIDTH = 4
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );

endinterface

// File: rtl/serial_sub_full_sub.sv
// full_sub: 1-bit combinational full subtractor, computes x - y - bi.
//   x, y, bi : minuend bit, subtrahend bit, borrow-in
//   d, bo    : difference bit, borrow-out
module full_sub (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  // Borrow when y beats x outright, or when they tie and a borrow is pending.
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial unsigned subtractor, diff = (a - b - bin) mod 2^WIDTH.
// One bit per clock, LSB first, through a single full_sub cell.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : serial_sub_if slave (start/a/b/bin in, busy/done/diff/bout out)
// A start accepted at edge E0 gives busy for WIDTH cycles and a one-cycle
// done pulse after edge E0+WIDTH. start is accepted in IDLE and DONE only.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_sub_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic             br_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             d_s;
  logic             bo_s;
  logic             last_s;

  full_sub u_full_sub (
    .x  (a_r[0]),
    .y  (b_r[0]),
    .bi (br_r),
    .d  (d_s),
    .bo (bo_s)
  );

  // The new difference bit enters at the MSB; after WIDTH shifts bit 0 lands at bit 0.
  assign res_nxt_s = WIDTH'({d_s, res_r} >> 1'b1);

  // Flags the edge that processes the final operand bit.
  always_comb begin
    last_s = 1'b0;
    if ((state_r == RUN) && (cnt_r == LAST_BIT)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Next-state logic of the IDLE/RUN/DONE controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_nxt_s = RUN;
        else           state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = RUN;
      end
      DONE: begin
        if (bus.start) state_nxt_s = RUN;
        else           state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register plus busy/done, registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Operand shift registers, borrow FF, bit counter and partial result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      res_r <= {WIDTH{1'b0}};
      br_r  <= 1'b0;
      cnt_r <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (bus.start) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            br_r  <= bus.bin;
            cnt_r <= {CW{1'b0}};
          end else begin
            a_r   <= a_r;
            b_r   <= b_r;
            br_r  <= br_r;
            cnt_r <= cnt_r;
          end
        end
        RUN: begin
          a_r   <= a_r >> 1'b1;
          b_r   <= b_r >> 1'b1;
          res_r <= res_nxt_s;
          br_r  <= bo_s;
          // Hold on the final bit so the counter never wraps.
          if (last_s) cnt_r <= cnt_r;
          else        cnt_r <= cnt_r + CW'(1);
        end
        default: begin
          a_r   <= a_r;
          b_r   <= b_r;
          res_r <= res_r;
          br_r  <= br_r;
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Published result: updated only on the RUN->DONE edge, held otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      diff_r <= {WIDTH{1'b0}};
      bout_r <= 1'b0;
    end else if (last_s) begin
      diff_r <= res_nxt_s;
      bout_r <= bo_s;
    end else begin
      diff_r <= diff_r;
      bout_r <= bout_r;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.diff = diff_r;
  assign bus.bout = bout_r;

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed self-checking bench for serial_sub at WIDTH = 4.
module tb_serial_sub;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  serial_sub_if #(.WIDTH(4)) bus ();

  serial_sub #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One operation from IDLE: checks latency, busy length, result.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        input logic [3:0] ed, input logic eb, input string tag);
    int  k;
    int  busy_cnt;
    bit  seen;
    k = 0; busy_cnt = 0; seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.bin = bin;
    for (int i = 1; i <= 12 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        k = i;
        check({tag, " busy@done"}, bus.busy, 1'b0);
      end else if (bus.busy) begin
        busy_cnt++;
      end
      if (i == 1) begin
        bus.start = 1'b0; bus.a = ~a; bus.b = ~b; bus.bin = ~bin;
      end
    end
    check({tag, " latency"}, k, 5);
    check({tag, " busy_cycles"}, busy_cnt, 4);
    check({tag, " diff"}, bus.diff, ed);
    check({tag, " bout"}, bus.bout, eb);
  endtask

  logic [3:0] ha [3] = '{4'h9, 4'h2, 4'hC};
  logic [3:0] hb [3] = '{4'h2, 4'h9, 4'h5};
  logic       hc [3] = '{1'b0, 1'b1, 1'b1};
  logic [3:0] hd [3] = '{4'h7, 4'h8, 4'h6};
  logic       hbo[3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    int  k;
    int  dones;
    bit  seen;
    logic [4:0] full;
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = 4'h0; bus.b = 4'h0; bus.bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", bus.busy, 1'b0);
    check("reset done", bus.done, 1'b0);
    check("reset diff", bus.diff, 4'h0);
    check("reset bout", bus.bout, 1'b0);
    rst_n = 1'b1;

    run_op(4'h7, 4'h3, 1'b0, 4'h4, 1'b0, "7-3-0");
    run_op(4'h3, 4'h4, 1'b1, 4'hE, 1'b1, "3-4-1");
    run_op(4'h0, 4'h0, 1'b1, 4'hF, 1'b1, "0-0-1");
    run_op(4'hF, 4'hF, 1'b0, 4'h0, 1'b0, "F-F-0");

    // Second start two cycles into RUN must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'h5; bus.b = 4'h2; bus.bin = 1'b0;
    dones = 0; k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.done) begin dones++; k = i; end
      if (i == 1) bus.start = 1'b0;
      if (i == 2) begin bus.start = 1'b1; bus.a = 4'hF; bus.b = 4'h0; bus.bin = 1'b1; end
      if (i == 3) bus.start = 1'b0;
    end
    check("ignore done_count", dones, 1);
    check("ignore latency", k, 5);
    check("ignore diff", bus.diff, 4'h3);
    check("ignore bout", bus.bout, 1'b0);

    // start held high: back-to-back results every 5 cycles.
    @(negedge clk);
    bus.start = 1'b1; bus.a = ha[0]; bus.b = hb[0]; bus.bin = hc[0];
    for (int op = 0; op < 3; op++) begin
      seen = 1'b0; k = 0;
      for (int i = 1; i <= 12 && !seen; i++) begin
        @(negedge clk);
        if (i == 1) begin bus.a = ~bus.a; bus.b = ~bus.b; end
        if (bus.done) begin
          seen = 1'b1; k = i;
          check($sformatf("held%0d diff", op), bus.diff, hd[op]);
          check($sformatf("held%0d bout", op), bus.bout, hbo[op]);
          if (op < 2) begin bus.a = ha[op+1]; bus.b = hb[op+1]; bus.bin = hc[op+1]; end
          else        bus.start = 1'b0;
        end
      end
      check($sformatf("held%0d period", op), k, 5);
    end

    // Reset during RUN cycle 2 aborts the operation.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'h9; bus.b = 4'h1; bus.bin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort busy", bus.busy, 1'b0);
    check("abort done", bus.done, 1'b0);
    check("abort diff", bus.diff, 4'h0);
    check("abort bout", bus.bout, 1'b0);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort no_done", dones, 0);
    run_op(4'h6, 4'h6, 1'b1, 4'hF, 1'b1, "after_abort");

    // Exhaustive sweep against an arithmetic reference.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          full = 5'(x - y - c);
          run_op(4'(x), 4'(y), 1'(c), full[3:0], (x < y + c),
                 $sformatf("sweep %0h-%0h-%0d", x, y, c));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
